// File: rtl/jtag_dtm_tap.sv
// JTAG TAP controller and RISC-V debug transport module, oversampled in the clk domain.
// Turns DMI scans into valid/ready requests toward the debug module.
//
// state  | meaning
// TLR    | test-logic-reset, IR forced to IDCODE, dmistat cleared
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | load the selected DR
// SH_DR  | shift DR, LSB out on TDO
// EX1_DR | exit1 DR
// PAU_DR | pause DR
// EX2_DR | exit2 DR
// UPD_DR | apply DR (DMI request / DTMCS reset)
// SEL_IR | select IR scan
// CAP_IR | load 5'b00001 into IR shifter
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR
// EX2_IR | exit2 IR
// UPD_IR | copy IR shifter into IR
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE    = 32'h1e200a6d,
    parameter int          ABITS     = 6,
    parameter logic [2:0]  IDLE_HINT = 3'd5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jtag_TCK,
    input  logic             jtag_TMS,
    input  logic             jtag_TDI,
    output logic             jtag_TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);

    localparam int DRW = ABITS + 34;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t state_q, state_d;

    logic tck_s1, tck_s2, tck_s3;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic tck_rise, tck_fall;

    logic [4:0]       ir_q, ir_shift;
    logic [DRW-1:0]   dr_q, dr_shifted, dr_capture;
    logic             ir_idcode, ir_dtmcs, ir_dmi;

    logic [ABITS-1:0] last_addr;
    logic [31:0]      last_data;
    logic [1:0]       dmistat;
    logic [1:0]       op_status;
    logic             pending;
    logic             drop_resp;

    logic [ABITS-1:0] upd_addr;
    logic [31:0]      upd_data;
    logic [1:0]       upd_op;
    logic [31:0]      dtmcs_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_s1 <= 1'b0;
            tck_s2 <= 1'b0;
            tck_s3 <= 1'b0;
            tms_s1 <= 1'b0;
            tms_s2 <= 1'b0;
            tdi_s1 <= 1'b0;
            tdi_s2 <= 1'b0;
        end else begin
            tck_s1 <= jtag_TCK;
            tck_s2 <= tck_s1;
            tck_s3 <= tck_s2;
            tms_s1 <= jtag_TMS;
            tms_s2 <= tms_s1;
            tdi_s1 <= jtag_TDI;
            tdi_s2 <= tdi_s1;
        end
    end

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 & tck_s3;

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s2 ? TLR    : RTI;
                RTI:     state_d = tms_s2 ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s2 ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s2 ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s2 ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s2 ? UPD_DR : PAU_DR;
                PAU_DR:  state_d = tms_s2 ? EX2_DR : PAU_DR;
                EX2_DR:  state_d = tms_s2 ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s2 ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s2 ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s2 ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s2 ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s2 ? UPD_IR : PAU_IR;
                PAU_IR:  state_d = tms_s2 ? EX2_IR : PAU_IR;
                EX2_IR:  state_d = tms_s2 ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s2 ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    assign ir_idcode = (ir_q == 5'h01);
    assign ir_dtmcs  = (ir_q == 5'h10);
    assign ir_dmi    = (ir_q == 5'h11);

    assign op_status = pending ? 2'd3 : dmistat;
    assign dtmcs_val = {14'b0, 2'b0, 1'b0, IDLE_HINT, dmistat, 6'(ABITS), 4'd1};

    // TDI enters at the top of whichever DR width the current instruction selects.
    always_comb begin
        dr_shifted = '0;
        dr_capture = '0;
        if (ir_dmi) begin
            dr_shifted = {tdi_s2, dr_q[DRW-1:1]};
            dr_capture = {last_addr, last_data, op_status};
        end else if (ir_idcode) begin
            dr_shifted[31:0] = {tdi_s2, dr_q[31:1]};
            dr_capture[31:0] = IDCODE;
        end else if (ir_dtmcs) begin
            dr_shifted[31:0] = {tdi_s2, dr_q[31:1]};
            dr_capture[31:0] = dtmcs_val;
        end else begin
            dr_shifted[0] = tdi_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TLR;
            ir_q     <= 5'h01;
            ir_shift <= 5'h00;
            dr_q     <= '0;
            jtag_TDO <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == TLR) ir_q <= 5'h01;
            if (tck_rise) begin
                case (state_q)
                    CAP_IR:  ir_shift <= 5'b00001;
                    SH_IR:   ir_shift <= {tdi_s2, ir_shift[4:1]};
                    UPD_IR:  ir_q     <= ir_shift;
                    CAP_DR:  dr_q     <= dr_capture;
                    SH_DR:   dr_q     <= dr_shifted;
                    default: ;
                endcase
            end
            if (tck_fall) begin
                if (state_q == SH_IR)      jtag_TDO <= ir_shift[0];
                else if (state_q == SH_DR) jtag_TDO <= dr_q[0];
            end
        end
    end

    assign upd_addr = dr_q[DRW-1:34];
    assign upd_data = dr_q[33:2];
    assign upd_op   = dr_q[1:0];

    assign dmi_resp_ready = 1'b1;

    // pending spans request issue through response; drop_resp eats the reply of an abandoned request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
            last_addr     <= '0;
            last_data     <= '0;
            dmistat       <= 2'd0;
            pending       <= 1'b0;
            drop_resp     <= 1'b0;
        end else begin
            if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
            if (dmi_resp_valid) begin
                if (drop_resp) begin
                    drop_resp <= 1'b0;
                end else if (pending) begin
                    last_data <= dmi_resp_data;
                    if (dmistat == 2'd0) dmistat <= dmi_resp_op;
                    pending <= 1'b0;
                end
            end
            if (tck_rise && state_q == CAP_DR && ir_dmi && pending) dmistat <= 2'd3;
            if (tck_rise && state_q == UPD_DR) begin
                if (ir_dmi) begin
                    if (pending) begin
                        dmistat <= 2'd3;
                    end else if ((upd_op == 2'd1 || upd_op == 2'd2) && dmistat == 2'd0) begin
                        dmi_req_valid <= 1'b1;
                        dmi_req_addr  <= upd_addr;
                        dmi_req_data  <= upd_data;
                        dmi_req_op    <= upd_op;
                        last_addr     <= upd_addr;
                        pending       <= 1'b1;
                    end
                end else if (ir_dtmcs && (dr_q[16] || dr_q[17])) begin
                    dmistat <= 2'd0;
                    if (dr_q[17]) begin
                        dmi_req_valid <= 1'b0;
                        pending       <= 1'b0;
                        if (pending && !dmi_resp_valid) drop_resp <= 1'b1;
                    end
                end
            end
            if (state_q == TLR) dmistat <= 2'd0;
        end
    end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Bench for jtag_dtm_tap: bit-banged JTAG host, a small DM responder and a scoreboard
// holding the DM memory contents the scans are expected to read back.
module tb_jtag_dtm_tap;

    localparam logic [31:0] IDCODE = 32'h1e200a6d;

    logic        clk;
    logic        rst_n;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;
    logic        dmi_req_valid, dmi_req_ready;
    logic [5:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_op;

    jtag_dtm_tap dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jtag_TCK       (jtag_TCK),
        .jtag_TMS       (jtag_TMS),
        .jtag_TDI       (jtag_TDI),
        .jtag_TDO       (jtag_TDO),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_req_op     (dmi_req_op),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_data  (dmi_resp_data),
        .dmi_resp_op    (dmi_resp_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          pulses = 0;
    int          hs_count = 0;
    logic [5:0]  hs_addr;
    logic [31:0] hs_data;
    logic [1:0]  hs_op;
    logic        dm_stall = 1'b0;
    logic [31:0] dm_mem  [64];
    logic [31:0] ref_mem [64];

    typedef struct {
        logic [4:0]  ir;
        int          n;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (2) @(negedge clk);
        tdo = jtag_TDO;
        jtag_TCK = 1'b1;
        repeat (4) @(negedge clk);
        jtag_TCK = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rti(input int n);
        logic t;
        for (int i = 0; i < n; i++) tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic t;
        dout = '0;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], t);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic shift_ir(input logic [4:0] ir, output logic [4:0] dout);
        logic t;
        dout = '0;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, ir[i], t);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    // DM responder: random accept delay, response either with the accept or a few cycles later.
    initial begin
        logic [5:0]  a;
        logic [31:0] rdata;
        int          d1, d2;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = '0;
        dmi_resp_op    = 2'd0;
        forever begin
            @(negedge clk);
            dmi_req_ready  = 1'b0;
            dmi_resp_valid = 1'b0;
            if (dmi_req_valid && !dm_stall) begin
                d1 = $urandom_range(0, 3);
                d2 = $urandom_range(0, 4);
                repeat (d1) @(negedge clk);
                a = dmi_req_addr;
                if (dmi_req_op == 2'd2) dm_mem[a] = dmi_req_data;
                rdata = dm_mem[a];
                dmi_req_ready = 1'b1;
                if (d2 == 0) begin
                    dmi_resp_valid = 1'b1;
                    dmi_resp_data  = rdata;
                end
                @(negedge clk);
                dmi_req_ready  = 1'b0;
                dmi_resp_valid = 1'b0;
                if (d2 != 0) begin
                    repeat (d2 - 1) @(negedge clk);
                    dmi_resp_valid = 1'b1;
                    dmi_resp_data  = rdata;
                    @(negedge clk);
                    dmi_resp_valid = 1'b0;
                end
            end
        end
    end

    // Request monitor: counts valid pulses, records handshakes, checks fields hold while stalled.
    initial begin
        logic        pv, pr;
        logic [39:0] pf;
        pv = 1'b0;
        pr = 1'b0;
        pf = '0;
        forever begin
            @(posedge clk);
            if (pv && !pr && rst_n)
                check("req_hold", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, {1'b1, pf});
            if (dmi_req_valid && !pv) pulses++;
            if (dmi_req_valid && dmi_req_ready) begin
                hs_count++;
                hs_addr = dmi_req_addr;
                hs_data = dmi_req_data;
                hs_op   = dmi_req_op;
            end
            pv = dmi_req_valid;
            pr = dmi_req_ready;
            pf = {dmi_req_addr, dmi_req_data, dmi_req_op};
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t;
        logic [63:0] dout;
        logic [4:0]  irout;
        logic [5:0]  a;
        logic [31:0] d, exp_data;
        logic [1:0]  o;
        logic [39:0] pat;
        int          p0, h0;

        for (int i = 0; i < 64; i++) begin
            dm_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        dm_mem[6'h11]  = 32'hA5A5_0001;
        ref_mem[6'h11] = 32'hA5A5_0001;
        dm_mem[6'h05]  = 32'hCAFE_0005;
        ref_mem[6'h05] = 32'hCAFE_0005;

        vecs[0] = '{ir: 5'h01, n: 32, din: 64'h0,  exp: 64'h1e200a6d};
        vecs[1] = '{ir: 5'h10, n: 32, din: 64'h0,  exp: 64'h00005061};
        vecs[2] = '{ir: 5'h1f, n: 5,  din: 64'h0d, exp: 64'h1a};
        vecs[3] = '{ir: 5'h03, n: 8,  din: 64'ha5, exp: 64'h4a};
        vecs[4] = '{ir: 5'h11, n: 40, din: 64'h0,  exp: 64'h0};

        rst_n    = 1'b0;
        jtag_TCK = 1'b0;
        jtag_TMS = 1'b1;
        jtag_TDI = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tdo", jtag_TDO, 0);
        check("rst_req_valid", dmi_req_valid, 0);
        check("rst_resp_ready", dmi_resp_ready, 1);
        check("rst_req_fields", {dmi_req_addr, dmi_req_data, dmi_req_op}, 0);

        for (int i = 0; i < 8; i++) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        shift_dr(32, 64'h0, dout);
        check("idcode_default", dout, IDCODE);

        for (int i = 0; i < 5; i++) begin
            shift_ir(vecs[i].ir, irout);
            check($sformatf("vec%0d_ir_out", i), irout, 5'b00001);
            shift_dr(vecs[i].n, vecs[i].din, dout);
            check($sformatf("vec%0d_dr_out", i), dout, vecs[i].exp);
        end

        // write addr 0x10, then nop read-back
        p0 = pulses;
        h0 = hs_count;
        shift_dr(40, {24'h0, 6'h10, 32'h0, 2'd2}, dout);
        rti(6);
        check("wr_pulses", pulses, p0 + 1);
        check("wr_handshakes", hs_count, h0 + 1);
        check("wr_fields", {hs_addr, hs_data, hs_op}, {6'h10, 32'h0, 2'd2});
        shift_dr(40, 64'h0, dout);
        check("wr_nop_op", dout[1:0], 2'd0);
        check("wr_nop_all", dout, {24'h0, 6'h10, 32'h0, 2'd0});
        check("nop_no_request", pulses, p0 + 1);

        // read addr 0x11
        shift_dr(40, {24'h0, 6'h11, 32'h0, 2'd1}, dout);
        rti(5);
        shift_dr(40, 64'h0, dout);
        check("rd_data", dout[33:2], 32'hA5A5_0001);
        check("rd_op", dout[1:0], 2'd0);
        check("rd_addr", dout[39:34], 6'h11);

        // busy: DM holds ready low, second scan lands while outstanding
        dm_stall = 1'b1;
        p0 = pulses;
        shift_dr(40, {24'h0, 6'h05, 32'h0, 2'd1}, dout);
        shift_dr(40, {24'h0, 6'h06, 32'h0000_1234, 2'd2}, dout);
        check("busy_capture_op", dout[1:0], 2'd3);
        rti(3);
        @(negedge clk);
        dm_stall = 1'b0;
        rti(6);
        check("busy_one_request", pulses, p0 + 1);
        check("busy_req_addr", hs_addr, 6'h05);
        shift_ir(5'h10, irout);
        shift_dr(32, 64'h0001_0000, dout);
        shift_dr(32, 64'h0, dout);
        check("dtmcs_after_dmireset", dout, 64'h5061);
        shift_ir(5'h11, irout);
        shift_dr(40, 64'h0, dout);
        check("busy_rd_data", dout[33:2], ref_mem[5]);
        check("busy_rd_op", dout[1:0], 2'd0);

        // randomized transactions against the scoreboard
        for (int k = 0; k < 16; k++) begin
            a = 6'($urandom_range(0, 63));
            d = $urandom;
            o = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd1;
            p0 = pulses;
            h0 = hs_count;
            shift_dr(40, {24'h0, a, d, o}, dout);
            rti(6);
            check("rand_pulses", pulses, p0 + 1);
            check("rand_fields", {hs_addr, hs_data, hs_op}, {a, d, o});
            exp_data = (o == 2'd2) ? d : ref_mem[a];
            if (o == 2'd2) ref_mem[a] = d;
            shift_dr(40, 64'h0, dout);
            check("rand_nop", dout, {24'h0, a, exp_data, 2'd0});
        end

        // reset in the middle of a DMI write shift
        p0 = pulses;
        pat = {6'h2a, 32'hdead_beef, 2'd2};
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < 12; i++) tck_cycle(1'b0, pat[i], t);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midscan_rst_valid", dmi_req_valid, 0);
        check("midscan_rst_tdo", jtag_TDO, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rti(3);
        repeat (20) @(negedge clk);
        check("midscan_no_request", pulses, p0);
        shift_dr(32, 64'h0, dout);
        check("midscan_ir_idcode", dout, IDCODE);
        check("midscan_no_request_after", pulses, p0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
